// File: rtl/step_translator_if.sv
// rtl/step_translator_if.sv - MotorPhase broadcast bus shared by the translator and the phase drivers
interface step_translator_if;
  logic [4:0] addr_bus;
  logic       I0_bus;
  logic       I1_bus;
  logic       Phase_bus;

  modport master (output addr_bus, I0_bus, I1_bus, Phase_bus);
  modport slave  (input  addr_bus, I0_bus, I1_bus, Phase_bus);
endinterface

// File: rtl/step_translator.sv
// rtl/step_translator.sv - step/dir/microstep to A3988 phase-current writes for two steppers
module step_translator #(
  parameter logic [4:0] BASE_ADDR = 5'd0,
  parameter logic [4:0] IDLE_ADDR = 5'h1F,
  parameter logic [3:0] RESET_POS = 4'd2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              step,
  input  logic [1:0]              dir,
  input  logic [1:0]              ms1,
  input  logic [1:0]              ms2,
  step_translator_if.master       bus,
  output logic [3:0]              pos0,
  output logic [3:0]              pos1,
  output logic                    busy
);

  typedef enum logic [2:0] {S_IDLE, S_M0A, S_M0B, S_M1A, S_M1B} state_t;

  logic [1:0] step_s1, step_s2, step_d;
  logic [1:0] dir_s1, dir_s2;
  logic [1:0] ms1_s1, ms1_s2;
  logic [1:0] ms2_s1, ms2_s2;
  logic [1:0] step_evt;

  logic [3:0] pos0_q, pos1_q;
  logic [1:0] dirty_q, dirty_clr;

  state_t     state_q, state_d;
  logic [3:0] snap_q, snap_d;
  logic [4:0] addr_q, addr_d;
  logic [1:0] lvl_q, lvl_d;
  logic       ph_q, ph_d;

  function automatic logic [3:0] next_pos(input logic [3:0] p, input logic d,
                                          input logic [1:0] ms);
    logic [3:0] inc;
    case (ms)
      2'b00:   inc = 4'd4;
      2'b01:   inc = 4'd2;
      default: inc = 4'd1;
    endcase
    return d ? p + inc : p - inc;
  endfunction

  // |cos| repeats every 8 positions; sin is cos shifted back by 4 positions.
  function automatic logic [1:0] cos_level(input logic [3:0] p);
    case (p[2:0])
      3'd0, 3'd1, 3'd7: return 2'b00;
      3'd2, 3'd6:       return 2'b01;
      3'd3, 3'd5:       return 2'b10;
      default:          return 2'b11;
    endcase
  endfunction

  function automatic logic cos_phase(input logic [3:0] p);
    return (p <= 4'd4) || (p >= 4'd12);
  endfunction

  function automatic logic sin_phase(input logic [3:0] p);
    return (p <= 4'd8);
  endfunction

  assign step_evt = step_s2 & ~step_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_s1 <= '0; step_s2 <= '0; step_d <= '0;
      dir_s1  <= '0; dir_s2  <= '0;
      ms1_s1  <= '0; ms1_s2  <= '0;
      ms2_s1  <= '0; ms2_s2  <= '0;
    end else begin
      step_s1 <= step;  step_s2 <= step_s1; step_d <= step_s2;
      dir_s1  <= dir;   dir_s2  <= dir_s1;
      ms1_s1  <= ms1;   ms1_s2  <= ms1_s1;
      ms2_s1  <= ms2;   ms2_s2  <= ms2_s1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos0_q <= RESET_POS;
      pos1_q <= RESET_POS;
    end else begin
      if (step_evt[0]) pos0_q <= next_pos(pos0_q, dir_s2[0], {ms2_s2[0], ms1_s2[0]});
      if (step_evt[1]) pos1_q <= next_pos(pos1_q, dir_s2[1], {ms2_s2[1], ms1_s2[1]});
    end
  end

  assign dirty_clr = {state_d == S_M1A, state_d == S_M0A};

  // A step landing on the same edge as the clear keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dirty_q <= 2'b11;
    else        dirty_q <= (dirty_q & ~dirty_clr) | step_evt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      snap_q  <= RESET_POS;
      addr_q  <= IDLE_ADDR;
      lvl_q   <= 2'b11;
      ph_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      addr_q  <= addr_d;
      lvl_q   <= lvl_d;
      ph_q    <= ph_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = dirty_q[0] ? S_M0A : (dirty_q[1] ? S_M1A : S_IDLE);
      S_M0A:  state_d = S_M0B;
      S_M1A:  state_d = S_M1B;
      S_M0B:  state_d = dirty_q[1] ? S_M1A : (dirty_q[0] ? S_M0A : S_IDLE);
      S_M1B:  state_d = dirty_q[0] ? S_M0A : (dirty_q[1] ? S_M1A : S_IDLE);
      default: state_d = S_IDLE;
    endcase
  end

  // Bus registers are loaded from the upcoming state so the write appears on the entry edge.
  always_comb begin
    snap_d = snap_q;
    addr_d = IDLE_ADDR;
    lvl_d  = 2'b11;
    ph_d   = 1'b0;
    case (state_d)
      S_M0A: begin
        snap_d = pos0_q;
        addr_d = BASE_ADDR;
        lvl_d  = cos_level(pos0_q);
        ph_d   = cos_phase(pos0_q);
      end
      S_M0B: begin
        addr_d = BASE_ADDR + 5'd1;
        lvl_d  = cos_level(snap_q - 4'd4);
        ph_d   = sin_phase(snap_q);
      end
      S_M1A: begin
        snap_d = pos1_q;
        addr_d = BASE_ADDR + 5'd2;
        lvl_d  = cos_level(pos1_q);
        ph_d   = cos_phase(pos1_q);
      end
      S_M1B: begin
        addr_d = BASE_ADDR + 5'd3;
        lvl_d  = cos_level(snap_q - 4'd4);
        ph_d   = sin_phase(snap_q);
      end
      default: ;
    endcase
  end

  assign bus.addr_bus  = addr_q;
  assign bus.I1_bus    = lvl_q[1];
  assign bus.I0_bus    = lvl_q[0];
  assign bus.Phase_bus = ph_q;
  assign pos0          = pos0_q;
  assign pos1          = pos1_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: doc/step_translator.md
# step_translator

Converts step/dir/microstep-mode inputs for two bipolar steppers into A3988 phase-current commands. It broadcasts those commands on the shared MotorPhase bus (`addr_bus`, `I0_bus`, `I1_bus`, `Phase_bus`). It sits directly upstream of the four MotorPhase instances, which latch bus values when `addr_bus` equals their address. It keeps a 16-position electrical angle per motor and writes a motor's two phases only when its position has changed.

## Interface
- `BASE_ADDR`, default 5'd0: address of motor 0 phase A. Motor 0 phase B, motor 1 phase A and motor 1 phase B use BASE+1, BASE+2 and BASE+3.
- `IDLE_ADDR`, default 5'h1F: address driven when no write is in progress. No MotorPhase instance uses it.
- `RESET_POS`, default 4'd2: electrical position after reset (45°).
- `clk`, input, 1: system clock (`osc_clk`, 2.08 MHz).
- `reset`, input, 1: asynchronous, active-low reset.
- `step`, input, 2: Step pin per motor; bit 0 = motor 0. Asynchronous.
- `dir`, input, 2: 1 = increment position, 0 = decrement. Asynchronous.
- `ms1`, input, 2: microstep select LSB. Asynchronous.
- `ms2`, input, 2: microstep select MSB. Asynchronous.
- `addr_bus`, output, 5: target phase address; registered.
- `I0_bus`, output, 1: A3988 I0 for the addressed phase; registered.
- `I1_bus`, output, 1: A3988 I1 for the addressed phase; registered.
- `Phase_bus`, output, 1: A3988 PHASE for the addressed phase; registered.
- `pos0`, output, 4: motor 0 electrical position.
- `pos1`, output, 4: motor 1 electrical position.
- `busy`, output, 1: 1 while the FSM is in any state other than IDLE.

## Operation
- **Input synchronization:** every `step`, `dir`, `ms1` and `ms2` bit passes through a 2-flop synchronizer.
- **Step detection:** a step event is a synchronized rising edge of `step`. `dir`, `ms2` and `ms1` are taken from the synchronized values in the same cycle as the edge.
- **Position increment `inc`:** set by {ms2,ms1}.
  - 00 → 4 (full step)
  - 01 → 2 (half step)
  - 10 → 1 (quarter step)
  - 11 → 1 (quarter step)
- **Position update:** pos ← pos ± inc, modulo 16, with wrap-around in both directions. A mode change never realigns pos.
- **Current mapping:** p is the position; angle = p·22.5°. Phase A = cos, phase B = sin. Levels by |value|, as {I1,I0}:
  - 1.00 or 0.92 → 00 (100%)
  - 0.71 → 01 (67%)
  - 0.38 → 10 (33%)
  - 0 → 11 (off)
- **Phase sign:** Phase = 1 when value ≥ 0, else 0; a zero value gives Phase = 1.
  - Phase A = 1 for p ∈ {0..4, 12..15}.
  - Phase B = 1 for p ∈ {0..8}.
- **Dirty flags:** `dirty[m]` is set by every step event of motor m and cleared on entry to that motor's A state. If a set and a clear happen in the same cycle, the set wins. Reset value is 2'b11, so every reset forces a full refresh.
- **FSM states:** IDLE, M0A, M0B, M1A, M1B.
  - IDLE → M0A if dirty[0]; else M1A if dirty[1]; else stays IDLE.
  - M0A → M0B; M1A → M1B.
  - M0B → M1A if dirty[1]; else M0A if dirty[0]; else IDLE.
  - M1B → M0A if dirty[0]; else M1A if dirty[1]; else IDLE.
- **Snapshot:** on entry to xA the FSM captures the motor's position. xA and xB both drive values derived from that snapshot, so phase A and phase B of one write always belong to the same position.
- **Bus values per state:**
  - IDLE: addr = IDLE_ADDR, {I1,I0} = 11, Phase = 0.
  - M0A: addr = BASE. M0B: addr = BASE+1.
  - M1A: addr = BASE+2. M1B: addr = BASE+3.
- **Coalescing:** several steps that arrive before a write starts collapse into a single write of the latest position. No step is ever lost from pos.
- **Reset:** asserting `reset` at any time, including mid-write, immediately forces:
  - bus outputs to their IDLE values, `busy` = 0;
  - pos0 = pos1 = RESET_POS, FSM = IDLE, synchronizers = 0.

## Timing
- **Step-to-position latency:** `step` rises before clk edge k (setup met). pos updates at edge k+2 and dirty is set at k+2.
- **Step-to-bus latency:** if the FSM is IDLE, the bus shows phase A after edge k+3, phase B after k+4, and IDLE after k+5.
- **Write duration:** one motor write takes 2 cycles. Both motors back to back take 4 cycles, with no IDLE cycle between them.
- **Input constraints:** `step` must stay high ≥ 2 cycles and low ≥ 2 cycles. `dir` and `ms` must be stable from 1 cycle before the step rises until 3 cycles after.
- **Throughput:** step rate ≤ clk/4 per motor. Writes cannot fall behind at this rate, because coalescing covers any excess.
- **Refresh after reset:** on the first edge after release the FSM enters M0A, followed by M0B, M1A, M1B, then IDLE.

## Test plan
- **Reset refresh:** release reset with no steps → addr 0,1,2,3 on consecutive cycles, all with {I1,I0} = 01 and Phase = 1; then addr 1F, 11, 0; `busy` high for exactly 4 cycles.
- **Quarter step forward, motor 0:** ms = 10, dir = 1 → pos0 = 3; addr 0: {I1,I0} = 10, Phase = 1; addr 1: 00, Phase = 1; bus active at k+3 and k+4.
- **Full step reverse, motor 1:** ms = 00, dir = 0 → pos1 = 14; addr 2: 01, Phase = 1; addr 3: 01, Phase = 0.
- **Simultaneous steps:** both motors step in the same cycle → M0A, M0B, M1A, M1B back to back, each with its correct new values.
- **Wrap and coalescing:** 16 forward quarter steps on motor 0 at 4-cycle spacing → pos0 wraps 15→0 and ends at 2; the final write shows 01/1, 01/1; no bus write ever targets addr 2 or 3.
- **Reset mid-write:** assert reset during M0B → bus is IDLE within the same cycle; after release, the full 4-write refresh of position 2 follows.
